// File: rtl/axis_digest_splicer.sv
// AXI-Stream digest splicer: overwrites part of a packet's last beat with its digest (MODE=0) or appends a
// digest beat after it (MODE=1). Optional feature macro: DIGEST_TID_CHECK_EN (digest/packet tid pairing check).
module axis_digest_splicer #(
  parameter int DATA_W         = 512,
  parameter int ID_W           = 6,
  parameter int DIGEST_W       = 256,
  parameter int DIGEST_OFFSET  = 0,
  parameter int MODE           = 0,
  parameter int DIG_FIFO_DEPTH = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_data_tvalid,
  output logic                  s_data_tready,
  input  logic [DATA_W-1:0]     s_data_tdata,
  input  logic [DATA_W/8-1:0]   s_data_tkeep,
  input  logic [ID_W-1:0]       s_data_tid,
  input  logic                  s_data_tlast,
  input  logic                  s_dig_tvalid,
  output logic                  s_dig_tready,
  input  logic [DIGEST_W-1:0]   s_dig_tdata,
  input  logic [ID_W-1:0]       s_dig_tid,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic [ID_W-1:0]       m_axis_tid,
  output logic                  m_axis_tlast,
  output logic [31:0]           pkt_count,
  output logic                  err_tid,
  output logic [15:0]           err_count
);

  localparam int KEEP_W = DATA_W / 8;
  localparam int DIG_B  = DIGEST_W / 8;
  localparam int AW     = $clog2(DIG_FIFO_DEPTH);
  localparam int CNT_W  = AW + 1;

  if ((DIGEST_OFFSET * 8 + DIGEST_W > DATA_W) || (DIGEST_W > DATA_W)) begin : g_bad_cfg
    $error("axis_digest_splicer: digest does not fit inside one data beat");
  end

  function automatic logic [KEEP_W-1:0] dig_keep_mask(input int off);
    logic [KEEP_W-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if ((i >= off) && (i < off + DIG_B)) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [KEEP_W-1:0] MERGE_MASK = dig_keep_mask(DIGEST_OFFSET);
  localparam logic [KEEP_W-1:0] APP_MASK   = dig_keep_mask(0);

  typedef enum logic {S_PASS = 1'b0, S_APPEND = 1'b1} state_t;

  state_t                state_q;
  logic                  rdy_en_q;
  logic                  m_tvalid_q, m_tlast_q;
  logic [DATA_W-1:0]     m_tdata_q;
  logic [KEEP_W-1:0]     m_tkeep_q;
  logic [ID_W-1:0]       m_tid_q;
  logic [DIGEST_W-1:0]   app_dig_q;
  logic [31:0]           pkt_cnt_q;

  logic [DIGEST_W-1:0]   fifo_dig_q [DIG_FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic full_s, empty_s, out_free_s, d_hs_s, pop_s, push_s;
  logic [DIGEST_W-1:0]   head_dig_s;
  logic [DATA_W-1:0]     merged_data_s, app_data_s;

  assign full_s     = (cnt_q == CNT_W'(DIG_FIFO_DEPTH));
  assign empty_s    = (cnt_q == '0);
  assign head_dig_s = fifo_dig_q[rd_ptr_q];
  assign out_free_s = !m_tvalid_q || m_axis_tready;

  // A last beat is only taken once its digest is buffered, so the merge never waits mid-beat.
  assign s_data_tready = rdy_en_q && (state_q == S_PASS) && out_free_s && (!s_data_tlast || !empty_s);
  assign d_hs_s        = s_data_tvalid && s_data_tready;
  assign pop_s         = d_hs_s && s_data_tlast;
  assign s_dig_tready  = rdy_en_q && (!full_s || pop_s);
  assign push_s        = s_dig_tvalid && s_dig_tready;

  always_comb begin
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    merged_data_s = s_data_tdata;
    merged_data_s[DIGEST_OFFSET*8 +: DIGEST_W] = head_dig_s;
    app_data_s = '0;
    app_data_s[DIGEST_W-1:0] = app_dig_q;
  end

  always_ff @(posedge aclk) begin
    if (push_s) fifo_dig_q[wr_ptr_q] <= s_dig_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_PASS;
      rdy_en_q   <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tid_q    <= '0;
      m_tlast_q  <= 1'b0;
      app_dig_q  <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      case (state_q)
        S_PASS: begin
          if (d_hs_s) begin
            m_tvalid_q <= 1'b1;
            m_tid_q    <= s_data_tid;
            if (s_data_tlast && (MODE == 0)) begin
              m_tdata_q <= merged_data_s;
              m_tkeep_q <= s_data_tkeep | MERGE_MASK;
              m_tlast_q <= 1'b1;
            end else begin
              m_tdata_q <= s_data_tdata;
              m_tkeep_q <= s_data_tkeep;
              m_tlast_q <= 1'b0;
              if (s_data_tlast) begin
                app_dig_q <= head_dig_s;
                state_q   <= S_APPEND;
              end
            end
          end else if (m_axis_tready) begin
            m_tvalid_q <= 1'b0;
          end
        end
        // m_tid_q still holds the packet tid from its last data beat.
        S_APPEND: begin
          if (out_free_s) begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= app_data_s;
            m_tkeep_q  <= APP_MASK;
            m_tlast_q  <= 1'b1;
            state_q    <= S_PASS;
          end
        end
        default: state_q <= S_PASS;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pkt_cnt_q <= 32'd0;
    end else if (m_tvalid_q && m_axis_tready && m_tlast_q) begin
      pkt_cnt_q <= pkt_cnt_q + 32'd1;
    end
  end

`ifdef DIGEST_TID_CHECK_EN
  logic [ID_W-1:0] fifo_tid_q [DIG_FIFO_DEPTH];
  logic            err_tid_q;
  logic [15:0]     err_cnt_q;

  always_ff @(posedge aclk) begin
    if (push_s) fifo_tid_q[wr_ptr_q] <= s_dig_tid;
  end

  // A mismatch is only flagged; the beat is still merged with the popped digest.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_tid_q <= 1'b0;
      err_cnt_q <= 16'h0000;
    end else if (pop_s && (s_data_tid != fifo_tid_q[rd_ptr_q])) begin
      err_tid_q <= 1'b1;
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_tid   = err_tid_q;
  assign err_count = err_cnt_q;
`else
  logic unused_dig_tid_s;
  assign unused_dig_tid_s = ^s_dig_tid;
  assign err_tid   = 1'b0;
  assign err_count = 16'h0000;
`endif

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tid    = m_tid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign pkt_count     = pkt_cnt_q;

endmodule

// File: tb/tb_axis_digest_splicer.sv
// Directed bench for axis_digest_splicer: replace mode (dut0, defaults) and append mode (dut1, MODE=1).
module tb_axis_digest_splicer;
  localparam int DW = 512, KW = 64, IW = 6, GW = 256;
  localparam logic [63:0] KALL = '1;
  localparam logic [63:0] KLOW = 64'h0000_0000_FFFF_FFFF;
`ifdef DIGEST_TID_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic d0_vld, d0_rdy, d0_last, g0_vld, g0_rdy, m0_vld, m0_rdy, m0_last, e0_tid;
  logic [DW-1:0] d0_data, m0_data;
  logic [KW-1:0] d0_keep, m0_keep;
  logic [IW-1:0] d0_id, g0_id, m0_id;
  logic [GW-1:0] g0_data;
  logic [31:0]   p0_cnt;
  logic [15:0]   e0_cnt;

  logic d1_vld, d1_rdy, d1_last, g1_vld, g1_rdy, m1_vld, m1_rdy, m1_last, e1_tid;
  logic [DW-1:0] d1_data, m1_data;
  logic [KW-1:0] d1_keep, m1_keep;
  logic [IW-1:0] d1_id, g1_id, m1_id;
  logic [GW-1:0] g1_data;
  logic [31:0]   p1_cnt;
  logic [15:0]   e1_cnt;

  axis_digest_splicer dut0 (
    .aclk(clk), .aresetn(aresetn),
    .s_data_tvalid(d0_vld), .s_data_tready(d0_rdy), .s_data_tdata(d0_data), .s_data_tkeep(d0_keep),
    .s_data_tid(d0_id), .s_data_tlast(d0_last),
    .s_dig_tvalid(g0_vld), .s_dig_tready(g0_rdy), .s_dig_tdata(g0_data), .s_dig_tid(g0_id),
    .m_axis_tvalid(m0_vld), .m_axis_tready(m0_rdy), .m_axis_tdata(m0_data), .m_axis_tkeep(m0_keep),
    .m_axis_tid(m0_id), .m_axis_tlast(m0_last),
    .pkt_count(p0_cnt), .err_tid(e0_tid), .err_count(e0_cnt)
  );

  axis_digest_splicer #(.MODE(1)) dut1 (
    .aclk(clk), .aresetn(aresetn),
    .s_data_tvalid(d1_vld), .s_data_tready(d1_rdy), .s_data_tdata(d1_data), .s_data_tkeep(d1_keep),
    .s_data_tid(d1_id), .s_data_tlast(d1_last),
    .s_dig_tvalid(g1_vld), .s_dig_tready(g1_rdy), .s_dig_tdata(g1_data), .s_dig_tid(g1_id),
    .m_axis_tvalid(m1_vld), .m_axis_tready(m1_rdy), .m_axis_tdata(m1_data), .m_axis_tkeep(m1_keep),
    .m_axis_tid(m1_id), .m_axis_tlast(m1_last),
    .pkt_count(p1_cnt), .err_tid(e1_tid), .err_count(e1_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [639:0] exp0_q[$];
  logic [639:0] exp1_q[$];
  logic rnd_en0 = 1'b0;

  task automatic check_eq(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [639:0] pack(input logic last, input logic [5:0] id, input logic [63:0] keep,
                                        input logic [511:0] data);
    return {57'd0, last, id, keep, data};
  endfunction

  function automatic logic [255:0] dig_of(input int k);
    return {8{32'hD000_0000 + 32'(k)}};
  endfunction

  // Output monitors: scoreboard compare on each handshake, hold-stability check under back-pressure.
  logic stall0 = 1'b0, stall1 = 1'b0;
  logic [639:0] held0, held1;
  always @(negedge clk) begin
    if (!aresetn) begin
      stall0 <= 1'b0;
    end else begin
      if (stall0) check_eq("hold_stable0", pack(m0_last, m0_id, m0_keep, m0_data), held0);
      if (m0_vld && m0_rdy) begin
        check_eq("beat0_expected", 640'(exp0_q.size() != 0), 640'(1));
        if (exp0_q.size() != 0) check_eq("beat0", pack(m0_last, m0_id, m0_keep, m0_data), exp0_q.pop_front());
      end
      stall0 <= m0_vld && !m0_rdy;
      held0  <= pack(m0_last, m0_id, m0_keep, m0_data);
    end
  end
  always @(negedge clk) begin
    if (!aresetn) begin
      stall1 <= 1'b0;
    end else begin
      if (stall1) check_eq("hold_stable1", pack(m1_last, m1_id, m1_keep, m1_data), held1);
      if (m1_vld && m1_rdy) begin
        check_eq("beat1_expected", 640'(exp1_q.size() != 0), 640'(1));
        if (exp1_q.size() != 0) check_eq("beat1", pack(m1_last, m1_id, m1_keep, m1_data), exp1_q.pop_front());
      end
      stall1 <= m1_vld && !m1_rdy;
      held1  <= pack(m1_last, m1_id, m1_keep, m1_data);
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_en0) m0_rdy = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_beat0(input logic [511:0] data, input logic [63:0] keep, input logic [5:0] id, input logic last);
    int n = 0;
    d0_data = data; d0_keep = keep; d0_id = id; d0_last = last; d0_vld = 1'b1;
    do begin @(negedge clk); n++; end while (!d0_rdy && n < 500);
    check_eq("data0_accept", 640'(d0_rdy), 640'(1));
    @(posedge clk); #1;
    d0_vld = 1'b0; d0_last = 1'b0;
  endtask

  task automatic send_dig0(input logic [255:0] dig, input logic [5:0] id);
    int n = 0;
    g0_data = dig; g0_id = id; g0_vld = 1'b1;
    do begin @(negedge clk); n++; end while (!g0_rdy && n < 500);
    check_eq("dig0_accept", 640'(g0_rdy), 640'(1));
    @(posedge clk); #1;
    g0_vld = 1'b0;
  endtask

  task automatic send_beat1(input logic [511:0] data, input logic [63:0] keep, input logic [5:0] id, input logic last);
    int n = 0;
    d1_data = data; d1_keep = keep; d1_id = id; d1_last = last; d1_vld = 1'b1;
    do begin @(negedge clk); n++; end while (!d1_rdy && n < 500);
    check_eq("data1_accept", 640'(d1_rdy), 640'(1));
    @(posedge clk); #1;
    d1_vld = 1'b0; d1_last = 1'b0;
  endtask

  task automatic send_dig1(input logic [255:0] dig, input logic [5:0] id);
    int n = 0;
    g1_data = dig; g1_id = id; g1_vld = 1'b1;
    do begin @(negedge clk); n++; end while (!g1_rdy && n < 500);
    check_eq("dig1_accept", 640'(g1_rdy), 640'(1));
    @(posedge clk); #1;
    g1_vld = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] din;
    logic [255:0] dg;
    int stall_hi;
    aresetn = 1'b0;
    d0_vld = 1'b0; d0_last = 1'b0; d0_data = '0; d0_keep = '0; d0_id = '0;
    g0_vld = 1'b0; g0_data = '0; g0_id = '0; m0_rdy = 1'b1;
    d1_vld = 1'b0; d1_last = 1'b0; d1_data = '0; d1_keep = '0; d1_id = '0;
    g1_vld = 1'b0; g1_data = '0; g1_id = '0; m1_rdy = 1'b1;

    // Reset values and ready release timing.
    repeat (3) @(negedge clk);
    check_eq("rst_data_rdy", 640'(d0_rdy), 640'(0));
    check_eq("rst_dig_rdy", 640'(g0_rdy), 640'(0));
    check_eq("rst_m_vld", 640'(m0_vld), 640'(0));
    check_eq("rst_m_beat", pack(m0_last, m0_id, m0_keep, m0_data), 640'(0));
    check_eq("rst_pkt_cnt", 640'(p0_cnt), 640'(0));
    check_eq("rst_err", 640'({e0_tid, e0_cnt}), 640'(0));
    check_eq("rst_data_rdy1", 640'(d1_rdy), 640'(0));
    @(posedge clk); #1; aresetn = 1'b1;
    @(negedge clk);
    check_eq("rel_rdy_low", 640'({d0_rdy, g0_rdy}), 640'(0));
    @(negedge clk);
    check_eq("rel_rdy_high", 640'({d0_rdy, g0_rdy}), 640'(3));
    @(posedge clk); #1;

    // 3-beat packet, digest first; last beat keep upper half only, merge fills the low half.
    exp0_q.push_back(pack(1'b0, 6'd5, KALL, {64{8'h11}}));
    exp0_q.push_back(pack(1'b0, 6'd5, KALL, {64{8'h22}}));
    exp0_q.push_back(pack(1'b1, 6'd5, KALL, {{32{8'h33}}, {32{8'hA5}}}));
    send_dig0({32{8'hA5}}, 6'd5);
    send_beat0({64{8'h11}}, KALL, 6'd5, 1'b0);
    send_beat0({64{8'h22}}, KALL, 6'd5, 1'b0);
    send_beat0({64{8'h33}}, 64'hFFFF_FFFF_0000_0000, 6'd5, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("pkt_cnt_1", 640'(p0_cnt), 640'(1));
    @(posedge clk); #1;

    // Last beat waits 10 cycles for its digest.
    exp0_q.push_back(pack(1'b1, 6'd2, KLOW, {{32{8'h44}}, {32{8'hB6}}}));
    d0_data = {64{8'h44}}; d0_keep = 64'h1; d0_id = 6'd2; d0_last = 1'b1; d0_vld = 1'b1;
    stall_hi = 0;
    repeat (10) begin @(negedge clk); if (d0_rdy) stall_hi++; end
    check_eq("stall_ready_cycles", 640'(stall_hi), 640'(0));
    @(posedge clk); #1;
    g0_data = {32{8'hB6}}; g0_id = 6'd2; g0_vld = 1'b1;
    @(negedge clk);
    check_eq("late_dig_rdy", 640'({g0_rdy, d0_rdy}), 640'(2));
    @(posedge clk); #1; g0_vld = 1'b0;
    @(negedge clk);
    check_eq("late_data_rdy", 640'({d0_rdy, m0_vld}), 640'(2));
    @(posedge clk); #1; d0_vld = 1'b0; d0_last = 1'b0;
    @(negedge clk);
    check_eq("late_merged_vld", 640'(m0_vld), 640'(1));
    repeat (2) @(negedge clk);
    check_eq("pkt_cnt_2", 640'(p0_cnt), 640'(2));
    @(posedge clk); #1;

    // Fill digest FIFO (4 deep), 5th digest waits for the first pop.
    for (int i = 0; i < 5; i++) begin
      din = {16{32'hC0DE_0000 + 32'(i)}};
      exp0_q.push_back(pack(1'b1, 6'(i), KLOW, {din[511:256], dig_of(i)}));
    end
    for (int i = 0; i < 4; i++) send_dig0(dig_of(i), 6'(i));
    g0_data = dig_of(4); g0_id = 6'd4; g0_vld = 1'b1;
    @(negedge clk);
    check_eq("dig_full_rdy", 640'(g0_rdy), 640'(0));
    @(posedge clk); #1;
    fork
      begin
        int n5 = 0;
        do begin @(negedge clk); n5++; end while (!g0_rdy && n5 < 100);
        check_eq("dig5_wait", 640'(n5), 640'(1));
        @(posedge clk); #1; g0_vld = 1'b0;
      end
      send_beat0({16{32'hC0DE_0000}}, 64'h1, 6'd0, 1'b1);
    join
    for (int i = 1; i < 5; i++) send_beat0({16{32'hC0DE_0000 + 32'(i)}}, 64'h1, 6'(i), 1'b1);
    repeat (3) @(negedge clk);
    check_eq("pkt_cnt_7", 640'(p0_cnt), 640'(7));
    @(posedge clk); #1;

    // 100 packets of 1-3 beats under random output back-pressure.
    rnd_en0 = 1'b1;
    fork
      begin
        for (int k = 0; k < 100; k++) send_dig0(dig_of(k), 6'(k));
      end
      begin
        logic [511:0] bd;
        logic [63:0]  bk;
        int len;
        for (int k = 0; k < 100; k++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            bd = {16{32'(k * 16 + b)}};
            bk = {$urandom, $urandom};
            if (b == len - 1) exp0_q.push_back(pack(1'b1, 6'(k), bk | KLOW, {bd[511:256], dig_of(k)}));
            else              exp0_q.push_back(pack(1'b0, 6'(k), bk, bd));
            send_beat0(bd, bk, 6'(k), (b == len - 1));
          end
        end
      end
    join
    for (int i = 0; i < 3000 && exp0_q.size() != 0; i++) @(negedge clk);
    rnd_en0 = 1'b0;
    @(posedge clk); #2; m0_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rand_drained", 640'(exp0_q.size()), 640'(0));
    check_eq("pkt_cnt_107", 640'(p0_cnt), 640'(107));
    @(posedge clk); #1;

    // Append mode: single-beat packet, then a 2-beat packet.
    dg = {8{32'h600D_D16E}};
    din = {64{8'h5A}};
    exp1_q.push_back(pack(1'b0, 6'd7, 64'hFF, din));
    exp1_q.push_back(pack(1'b1, 6'd7, KLOW, {256'd0, dg}));
    send_dig1(dg, 6'd7);
    send_beat1(din, 64'hFF, 6'd7, 1'b1);
    @(negedge clk);
    check_eq("append_rdy_low", 640'(d1_rdy), 640'(0));
    @(negedge clk);
    check_eq("append_rdy_back", 640'(d1_rdy), 640'(1));
    @(posedge clk); #1;
    exp1_q.push_back(pack(1'b0, 6'd9, KALL, {64{8'h71}}));
    exp1_q.push_back(pack(1'b0, 6'd9, 64'hF, {64{8'h72}}));
    exp1_q.push_back(pack(1'b1, 6'd9, KLOW, {256'd0, dig_of(77)}));
    send_dig1(dig_of(77), 6'd9);
    send_beat1({64{8'h71}}, KALL, 6'd9, 1'b0);
    send_beat1({64{8'h72}}, 64'hF, 6'd9, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("append_drained", 640'(exp1_q.size()), 640'(0));
    check_eq("append_pkt_cnt", 640'(p1_cnt), 640'(2));
    @(posedge clk); #1;

    // Digest tid 3 against packet tid 4.
    din = {64{8'hE4}};
    exp0_q.push_back(pack(1'b1, 6'd4, KALL, {din[511:256], {32{8'h3C}}}));
    send_dig0({32{8'h3C}}, 6'd3);
    send_beat0(din, KALL, 6'd4, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("err_tid", 640'(e0_tid), 640'(ERR_EXP));
    check_eq("err_count", 640'(e0_cnt), 640'(ERR_EXP));
    @(posedge clk); #1;

    // Reset mid-packet with a beat held in the output register and a digest buffered.
    m0_rdy = 1'b0;
    send_dig0({32{8'hDE}}, 6'd1);
    send_beat0({64{8'h0B}}, KALL, 6'd1, 1'b0);
    aresetn = 1'b0;
    @(negedge clk);
    check_eq("midrst_m_vld", 640'(m0_vld), 640'(0));
    check_eq("midrst_m_beat", pack(m0_last, m0_id, m0_keep, m0_data), 640'(0));
    check_eq("midrst_cnts", 640'({p0_cnt, e0_tid, e0_cnt}), 640'(0));
    check_eq("midrst_rdy", 640'({d0_rdy, g0_rdy}), 640'(0));
    @(posedge clk); #1; aresetn = 1'b1; m0_rdy = 1'b1;
    @(posedge clk); #1;
    din = {64{8'hC1}};
    exp0_q.push_back(pack(1'b1, 6'd2, KALL, {din[511:256], {32{8'h9E}}}));
    send_dig0({32{8'h9E}}, 6'd2);
    send_beat0(din, KALL, 6'd2, 1'b1);
    repeat (3) @(negedge clk);
    check_eq("post_rst_drained", 640'(exp0_q.size()), 640'(0));
    check_eq("post_rst_pkt_cnt", 640'(p0_cnt), 640'(1));
    check_eq("post_rst_err", 640'({e0_tid, e0_cnt}), 640'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
